// File: rtl/key_cmd_pkg.sv
// Shared types and key-to-command mapping for the
// keypad command front end.
package key_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4,
    CMD_HARD_DROP = 3'd5,
    CMD_PAUSE     = 3'd6
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_REPEAT
  } state_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic cmd_t map_key(input logic [3:0] code);
    cmd_t c;
    case (code)
      4'h4:    c = CMD_LEFT;
      4'h6:    c = CMD_RIGHT;
      4'h2:    c = CMD_ROTATE;
      4'h8:    c = CMD_SOFT_DROP;
      4'h5:    c = CMD_HARD_DROP;
      4'h0:    c = CMD_PAUSE;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_repeatable(input cmd_t c);
    return (c == CMD_LEFT) ||
           (c == CMD_RIGHT) ||
           (c == CMD_SOFT_DROP);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO; a pop frees a slot
// for a push in the same cycle even when full.
module cmd_fifo
  import key_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  cmd_t i_din,
  input  logic i_pop,
  output cmd_t o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = o_empty ? CMD_NONE : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= f_inc(r_wr);
      if (w_pop)  r_rd <= f_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keypad debounce / auto-repeat controller feeding
// game commands into a small output FIFO.
module key_cmd_ctrl
  import key_cmd_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       overflow
);

  localparam int MAX_AB = (DEBOUNCE_TICKS > REPEAT_DELAY) ?
                          DEBOUNCE_TICKS : REPEAT_DELAY;
  localparam int MAX_T  = (MAX_AB > REPEAT_RATE) ?
                          MAX_AB : REPEAT_RATE;
  localparam int CW     = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_DB  = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] C_RD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] C_RR  = CW'(REPEAT_RATE);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic [3:0]    r_code;
  logic [3:0]    w_code_nx;
  logic          r_ovf;
  logic          w_same;
  logic          w_emit;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  cmd_t          w_cmd;
  cmd_t          w_dout;

  assign w_cmd     = map_key(r_code);
  assign w_same    = key_valid && (key_code == r_code);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_code_nx  = r_code;
    w_emit     = 1'b0;
    if (tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            w_state_nx = ST_DEBOUNCE;
            w_code_nx  = key_code;
            w_cnt_nx   = C_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (!key_valid) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end else if (!w_same) begin
            w_code_nx = key_code;
            w_cnt_nx  = C_ONE;
          end else if (w_cnt_inc >= C_DB) begin
            w_emit     = 1'b1;
            w_state_nx = ST_HELD;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        ST_HELD: begin
          if (!key_valid) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end else if (!w_same) begin
            w_state_nx = ST_DEBOUNCE;
            w_code_nx  = key_code;
            w_cnt_nx   = C_ONE;
          end else if (r_cnt >= C_RD) begin
            // non-repeatable key parked at the delay limit
            w_cnt_nx = C_RD;
          end else if (w_cnt_inc >= C_RD &&
                       is_repeatable(w_cmd)) begin
            w_emit     = 1'b1;
            w_state_nx = ST_REPEAT;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        ST_REPEAT: begin
          if (!key_valid) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end else if (!w_same) begin
            w_state_nx = ST_DEBOUNCE;
            w_code_nx  = key_code;
            w_cnt_nx   = C_ONE;
          end else if (w_cnt_inc >= C_RR) begin
            w_emit   = 1'b1;
            w_cnt_nx = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
      endcase
    end
  end

  assign w_push = w_emit && (w_cmd != CMD_NONE);
  assign w_pop  = cmd_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_code  <= w_code_nx;
      r_ovf   <= w_push && w_full && !w_pop;
    end
  end

  cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_din  (w_cmd),
    .i_pop  (cmd_ready),
    .o_dout (w_dout),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign cmd_valid = !w_empty;
  assign cmd       = w_dout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Scoreboard bench for key_cmd_ctrl: run-length key model,
// occupancy-counting queue model, handshake monitor.
module tb_key_cmd_ctrl;

  localparam int DB    = 4;
  localparam int RD    = 32;
  localparam int RR    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       overflow;

  int n_chk = 0;
  int n_pass = 0;

  int         m_len = 0;
  int         m_code = 0;
  int         m_occ = 0;
  bit         m_ovf = 1'b0;
  logic [2:0] exp_q[$];
  int         got[8];
  int         ovf_seen = 0;

  always #5 clk = ~clk;

  key_cmd_ctrl #(
    .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .key_valid(key_valid),
    .key_code (key_code),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .overflow (overflow)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  function automatic int ref_cmd(input int k);
    case (k)
      4:       return 1;
      6:       return 2;
      2:       return 3;
      8:       return 4;
      5:       return 5;
      0:       return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int total_got();
    int s = 0;
    for (int i = 0; i < 8; i++) s += got[i];
    return s;
  endfunction

  // Emission depends only on how many consecutive ticks
  // the same code has been seen.
  task automatic model(input bit rst, input bit tk,
                       input bit kv, input int kc,
                       input bit rdy);
    bit emit;
    bit pop;
    int c;
    if (rst) begin
      m_len = 0;
      m_occ = 0;
      m_ovf = 1'b0;
      exp_q.delete();
      return;
    end
    pop  = rdy && (m_occ > 0);
    emit = 1'b0;
    if (tk) begin
      if (!kv) m_len = 0;
      else if (m_len > 0 && kc == m_code) m_len++;
      else begin
        m_code = kc;
        m_len  = 1;
      end
      c = ref_cmd(m_code);
      if (m_len == DB) emit = 1'b1;
      else if ((c == 1 || c == 2 || c == 4) &&
               m_len >= DB + RD &&
               (m_len - DB - RD) % RR == 0) emit = 1'b1;
    end
    c = emit ? ref_cmd(m_code) : 0;
    m_ovf = 1'b0;
    if (pop) m_occ--;
    if (c != 0) begin
      if (m_occ < DEPTH) begin
        m_occ++;
        exp_q.push_back(3'(c));
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit tk, input bit kv,
                      input int kc, input bit rdy,
                      input bit rst = 1'b0);
    @(negedge clk);
    if (!tk) begin
      kv = 1'($urandom_range(0, 1));
      kc = int'($urandom_range(0, 15));
    end
    reset     = !rst;
    tick      = tk;
    key_valid = kv;
    key_code  = 4'(kc);
    cmd_ready = rdy;
    @(posedge clk);
    model(rst, tk, kv, kc, rdy);
  endtask

  task automatic ticks(input bit kv, input int kc,
                       input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 0, rdy);
      step(1'b1, kv, kc, rdy);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 1'b0, 0, rdy);
  endtask

  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(negedge clk);
      #1;
      check("valid", cmd_valid, exp_q.size() != 0);
      check("overflow", overflow, m_ovf);
      if (overflow === 1'b1) ovf_seen++;
      if (cmd_valid === 1'b1 && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_pop: got cmd %0d expected none",
                   cmd);
        end else begin
          e = exp_q.pop_front();
          check("cmd", cmd, e);
          got[cmd]++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int b;
    int o;
    int code;
    bit held;
    int codes[7] = '{4, 6, 2, 8, 5, 0, 7};

    repeat (3) step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    #2;
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_ovf", overflow, 0);
    idle(2, 1'b1);

    b = got[1];
    ticks(1'b1, 4, 3, 1'b1);
    #2 check("left_pre", cmd_valid, 0);
    step(1'b1, 1'b1, 4, 1'b1);
    #2;
    check("left_valid", cmd_valid, 1);
    check("left_cmd", cmd, 1);
    ticks(1'b0, 0, 1, 1'b1);
    idle(6, 1'b1);
    check("left_once", got[1] - b, 1);

    b = got[2];
    ticks(1'b1, 6, 3, 1'b1);
    ticks(1'b0, 0, 1, 1'b1);
    ticks(1'b1, 6, 3, 1'b1);
    idle(4, 1'b1);
    check("right_early", got[2] - b, 0);
    ticks(1'b1, 6, 1, 1'b1);
    ticks(1'b0, 0, 1, 1'b1);
    idle(6, 1'b1);
    check("right_once", got[2] - b, 1);

    b = got[1];
    ticks(1'b1, 4, DB + RD + 2 * RR, 1'b1);
    ticks(1'b0, 0, 1, 1'b1);
    idle(6, 1'b1);
    check("left_repeat", got[1] - b, 4);

    b = got[3];
    ticks(1'b1, 2, 100, 1'b1);
    ticks(1'b0, 0, 1, 1'b1);
    idle(6, 1'b1);
    check("rotate_once", got[3] - b, 1);
    b = total_got();
    ticks(1'b1, 7, 100, 1'b1);
    ticks(1'b0, 0, 1, 1'b1);
    idle(6, 1'b1);
    check("unmapped", total_got() - b, 0);

    b = got[5];
    o = ovf_seen;
    repeat (5) begin
      ticks(1'b1, 5, 4, 1'b0);
      ticks(1'b0, 0, 1, 1'b0);
    end
    idle(2, 1'b0);
    check("ovf_one", ovf_seen - o, 1);
    #2 check("full_valid", cmd_valid, 1);
    idle(10, 1'b1);
    check("drain_four", got[5] - b, 4);

    b = got[5];
    o = ovf_seen;
    repeat (4) begin
      ticks(1'b1, 5, 4, 1'b0);
      ticks(1'b0, 0, 1, 1'b0);
    end
    ticks(1'b1, 5, 3, 1'b0);
    step(1'b1, 1'b1, 5, 1'b1);
    ticks(1'b0, 0, 1, 1'b0);
    idle(2, 1'b0);
    check("full_pp_ovf", ovf_seen - o, 0);
    check("full_pp_pop", got[5] - b, 1);
    idle(10, 1'b1);
    check("full_pp_total", got[5] - b, 5);

    ticks(1'b1, 4, 10, 1'b0);
    step(1'b1, 1'b1, 4, 1'b0, 1'b1);
    #2 check("rst_hold_valid", cmd_valid, 0);
    b = got[1];
    ticks(1'b1, 4, 3, 1'b1);
    idle(3, 1'b1);
    check("rst_hold_none", got[1] - b, 0);
    ticks(1'b1, 4, 1, 1'b1);
    idle(4, 1'b1);
    check("rst_hold_fresh", got[1] - b, 1);
    ticks(1'b0, 0, 1, 1'b1);
    idle(4, 1'b1);

    code = 4;
    held = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 99) < 3)
        code = codes[$urandom_range(0, 6)];
      if ($urandom_range(0, 59) == 0) held = !held;
      step(1'($urandom_range(0, 1)), held, code,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 799) == 0);
    end
    ticks(1'b0, 0, 1, 1'b1);
    idle(12, 1'b1);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_cmd_ctrl.md
KEY_CMD_CTRL -- requirements
Module: key_cmd_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive matching samples required to accept a press.
REQ-002 SHALL have parameter REPEAT_DELAY, default 32: ticks held after acceptance before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 8: ticks between subsequent auto-repeats.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of two.
REQ-005 SHALL use one clock and a reset that is synchronous and active-low.
REQ-006 clk  input  1  system clock; sole clock, all state on posedge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 tick  input  1  one-cycle sample-enable pulse at scan rate, one per scan period.
REQ-009 key_valid  input  1  high when the scanner reports any key down.
REQ-010 key_code  input  4  hex code of the pressed key; meaningful only when key_valid=1.
REQ-011 cmd_ready  input  1  consumer accepts cmd this cycle.
REQ-012 cmd_valid  output  1  FIFO non-empty; cmd holds head entry.
REQ-013 cmd  output  3  game command: NONE=0, LEFT=1, RIGHT=2, ROTATE=3, SOFT_DROP=4, HARD_DROP=5, PAUSE=6.
REQ-014 overflow  output  1  one-cycle pulse when a command is dropped because the FIFO is full.

Function
REQ-015 Key map SHALL be: 4->LEFT, 6->RIGHT, 2->ROTATE, 8->SOFT_DROP, 5->HARD_DROP, 0->PAUSE; all other codes map to NONE.
REQ-016 NONE SHALL never be pushed; unmapped keys still run through the FSM but emit nothing.
REQ-017 FSM state SHALL advance only on cycles with tick=1; key inputs are ignored when tick=0.
REQ-018 FSM SHALL have states IDLE, DEBOUNCE, HELD, REPEAT, plus a tick counter and a captured code.
REQ-019 IDLE: tick with key_valid=1 -> DEBOUNCE, capture key_code, counter=1.
REQ-020 DEBOUNCE, tick with key_valid=1 and same code: counter+1; on reaching DEBOUNCE_TICKS, emit the mapped cmd, go to HELD, counter=0.
REQ-021 DEBOUNCE, tick with key_valid=0: go to IDLE; tick with a different code: stay in DEBOUNCE, recapture, counter=1.
REQ-022 HELD, tick with key_valid=0: go to IDLE; tick with a different code: DEBOUNCE, recapture, counter=1.
REQ-023 HELD, tick with same code: counter+1; on reaching REPEAT_DELAY, and only if cmd is LEFT, RIGHT or SOFT_DROP, emit, go to REPEAT, counter=0.
REQ-024 HELD with a non-repeatable cmd: counter SHALL saturate at REPEAT_DELAY; state remains HELD until release or code change.
REQ-025 REPEAT: same code emits every REPEAT_RATE ticks (counter resets to 0 on each emit); release -> IDLE; code change -> DEBOUNCE.
REQ-026 An emit SHALL push into the FIFO in the same cycle as the tick; cmd_valid rises the next cycle, with no bypass.
REQ-027 Pop SHALL occur when cmd_valid&&cmd_ready; an empty-FIFO cmd_ready is ignored.
REQ-028 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full; occupancy is unchanged.
REQ-029 Push to a full FIFO without a simultaneous pop SHALL drop the new cmd, keep contents, and pulse overflow for 1 cycle.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; entries SHALL leave in push order.
REQ-031 Counter width SHALL be $clog2(max(DEBOUNCE_TICKS,REPEAT_DELAY,REPEAT_RATE)+1); counters SHALL never wrap.

Reset
REQ-032 With reset=0 at posedge clk: state=IDLE, counter=0, captured code=0, FIFO empty, cmd_valid=0, cmd=NONE, overflow=0.
REQ-033 Reset mid-press SHALL discard all queued commands; the still-held key SHALL need a full new debounce and SHALL NOT be emitted at deassertion.

Structure
REQ-034 Package key_cmd_pkg SHALL hold the cmd_t enum, the FSM state enum, and the key-code-to-cmd map function.
REQ-035 The FIFO SHALL be a sub-module cmd_fifo (parameter FIFO_DEPTH, width of cmd_t) with push, pop, full, empty.

Verification
REQ-036 Hold key 4 for 4 ticks with cmd_ready=1 -> exactly one LEFT; cmd_valid high 1 cycle after the 4th tick.
REQ-037 Key 6 held 3 ticks, released, then held 4 -> only one RIGHT, after the second press's 4th tick.
REQ-038 Key 4 held 4+32+16 ticks -> LEFT at tick 4, repeats at ticks 36, 44, 52 (4 LEFT total).
REQ-039 Key 2 held 100 ticks -> exactly one ROTATE; key 7 held 100 ticks -> no cmd.
REQ-040 cmd_ready=0, five separate presses of key 5 -> 4 HARD_DROP queued, 1 overflow pulse on the 5th; then cmd_ready=1 drains 4 in order.
REQ-041 Full FIFO, push and pop in the same cycle -> occupancy stays 4, no overflow; reset mid-hold -> cmd_valid=0 and nothing emitted until 4 fresh ticks.
